// File: rtl/filtro_mac_secuenciador_if.sv
// Sample/coefficient/result bundle between the FIR sample source and the MAC sequencer.
interface filtro_mac_secuenciador_if #(
    parameter int unsigned N  = 25,
    parameter int unsigned AW = 3
);
    logic           inicio;
    logic [N-1:0]   muestra;
    logic           coef_we;
    logic [AW-1:0]  coef_dir;
    logic [N-1:0]   coef_dato;
    logic [2*N-1:0] suma;
    logic           bandera;
    logic           listo;
    logic           ocupado;

    modport master (
        output inicio, muestra, coef_we, coef_dir, coef_dato,
        input  suma, bandera, listo, ocupado
    );

    modport slave (
        input  inicio, muestra, coef_we, coef_dir, coef_dato,
        output suma, bandera, listo, ocupado
    );
endinterface

// File: rtl/filtro_mac_secuenciador.sv
// Sequential K-tap multiply-accumulate engine feeding the hold-register accumulator.
// Define FILTRO_SATURACION_EN to clamp each accumulate step instead of wrapping.
module filtro_mac_secuenciador #(
    parameter int unsigned N  = 25,
    parameter int unsigned K  = 8,
    parameter int unsigned AW = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    filtro_mac_secuenciador_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StMac, StPublica} estado_e;

    estado_e               estado_q, estado_d;
    logic signed [N-1:0]   x_q [K];
    logic signed [N-1:0]   c_q [K];
    logic [AW-1:0]         idx_q;
    logic signed [2*N-1:0] sum_q;
    logic signed [2*N-1:0] suma_q;
    logic signed [2*N-1:0] x_ext, c_ext, producto, acum;
    logic                  ultimo, acepta, escribe;

    assign ultimo  = (idx_q == AW'(K - 1));
    assign acepta  = (estado_q == StIdle) && bus.inicio;
    assign escribe = (estado_q == StIdle) && bus.coef_we && (32'(bus.coef_dir) < K);

    always_comb begin
        x_ext    = x_q[idx_q];
        c_ext    = c_q[idx_q];
        producto = x_ext * c_ext;
    end

`ifdef FILTRO_SATURACION_EN
    logic signed [2*N:0] ancho;

    // One guard bit exposes overflow; clamp towards the sign of the true result.
    always_comb begin
        ancho = {sum_q[2*N-1], sum_q} + {producto[2*N-1], producto};
        if (ancho[2*N] != ancho[2*N-1]) begin
            acum = ancho[2*N] ? {1'b1, {(2*N-1){1'b0}}} : {1'b0, {(2*N-1){1'b1}}};
        end else begin
            acum = ancho[2*N-1:0];
        end
    end
`else
    assign acum = sum_q + producto;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= StIdle;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StIdle:    if (acepta) estado_d = StMac;
            StMac:     if (ultimo) estado_d = StPublica;
            StPublica: estado_d = StIdle;
            default:   estado_d = StIdle;
        endcase
    end

    always_comb begin
        bus.ocupado = (estado_q != StIdle);
        bus.listo   = (estado_q == StPublica);
        bus.bandera = (estado_q != StPublica);
        bus.suma    = suma_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < K; i++) begin
                x_q[i] <= '0;
                c_q[i] <= '0;
            end
            sum_q  <= '0;
            suma_q <= '0;
            idx_q  <= '0;
        end else begin
            // A write alongside an accepted sample lands before the first MAC edge.
            if (escribe) begin
                c_q[bus.coef_dir] <= bus.coef_dato;
            end
            if (acepta) begin
                x_q[0] <= bus.muestra;
                for (int unsigned i = 1; i < K; i++) begin
                    x_q[i] <= x_q[i-1];
                end
                sum_q <= '0;
                idx_q <= '0;
            end
            if (estado_q == StMac) begin
                sum_q <= acum;
                idx_q <= idx_q + 1'b1;
                if (ultimo) begin
                    suma_q <= acum;
                end
            end
        end
    end

endmodule

// File: tb/tb_filtro_mac_secuenciador.sv
// Self-checking bench for filtro_mac_secuenciador against a dot-product reference model.
module tb_filtro_mac_secuenciador;

    localparam int unsigned N  = 25;
    localparam int unsigned K  = 8;
    localparam int unsigned AW = 3;
    localparam int          W  = 2 * N;
    localparam longint SAT_MAX = (longint'(1) <<< (W - 1)) - 1;
    localparam longint SAT_MIN = -(longint'(1) <<< (W - 1));

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    filtro_mac_secuenciador_if #(.N(N), .AW(AW)) bus ();

    filtro_mac_secuenciador #(.N(N), .K(K), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int m_x [K];
    int m_c [K];

    function automatic int sx(input int v);
        return (v <<< (32 - N)) >>> (32 - N);
    endfunction

    function automatic longint wrap2n(input longint v);
        return (v <<< (64 - W)) >>> (64 - W);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < K; i++) begin
            m_x[i] = 0;
            m_c[i] = 0;
        end
    endfunction

    function automatic void model_shift(input int s);
        for (int i = K - 1; i > 0; i--) m_x[i] = m_x[i-1];
        m_x[0] = s;
    endfunction

    // Dot product of delay line and coefficients, accumulated in tap order.
    function automatic longint model_sum();
        longint acc;
        longint p;
        acc = 0;
        for (int i = 0; i < K; i++) begin
            p = longint'(m_x[i]) * longint'(m_c[i]);
`ifdef FILTRO_SATURACION_EN
            acc = acc + p;
            if (acc > SAT_MAX) acc = SAT_MAX;
            else if (acc < SAT_MIN) acc = SAT_MIN;
`else
            acc = wrap2n(acc + p);
`endif
        end
        return acc;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input int dir, input int val);
        bus.coef_we   = 1'b1;
        bus.coef_dir  = dir[AW-1:0];
        bus.coef_dato = val[N-1:0];
        @(posedge clk);
        #1;
        bus.coef_we = 1'b0;
        @(negedge clk);
        if (dir < K) m_c[dir] = sx(val);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_sample(input int s, input bit spam, input bit busy_wr,
                              input bit co_wr, input int co_dir, input int co_val,
                              output longint got);
        int     n;
        bit     seen;
        longint exp_v;
        bus.inicio  = 1'b1;
        bus.muestra = s[N-1:0];
        if (co_wr) begin
            bus.coef_we   = 1'b1;
            bus.coef_dir  = co_dir[AW-1:0];
            bus.coef_dato = co_val[N-1:0];
        end
        @(posedge clk);
        if (co_wr) m_c[co_dir] = sx(co_val);
        model_shift(sx(s));
        exp_v = model_sum();
        #1;
        bus.coef_we = 1'b0;
        if (spam) bus.muestra = 25'h0ABCDE;
        else bus.inicio = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 2 * K) begin
            @(posedge clk);
            n++;
            if (busy_wr && n == 2) begin
                #1;
                bus.coef_we   = 1'b1;
                bus.coef_dir  = '0;
                bus.coef_dato = 25'd99;
            end
            if (busy_wr && n == 3) begin
                #1;
                bus.coef_we = 1'b0;
            end
            @(negedge clk);
            if (bus.listo === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != K) begin
            errors++;
            $display("FAIL latency: listo after %0d cycles (seen=%0b), required %0d", n, seen, K);
        end
        got = longint'($signed(bus.suma));
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL suma: sample %0d got %0d, required %0d", s, got, exp_v);
        end
        checks++;
        if (bus.bandera !== 1'b0 || bus.ocupado !== 1'b1) begin
            errors++;
            $display("FAIL publish_flags: bandera=%b ocupado=%b, required 0 1",
                     bus.bandera, bus.ocupado);
        end
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.bandera !== 1'b1 || bus.listo !== 1'b0 || bus.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL restore: bandera=%b listo=%b ocupado=%b, required 1 0 0",
                     bus.bandera, bus.listo, bus.ocupado);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.suma !== '0) begin
            errors++;
            $display("FAIL reset_suma: got %0d, required 0", bus.suma);
        end
        checks++;
        if (bus.bandera !== 1'b1) begin
            errors++;
            $display("FAIL reset_bandera: got %b, required 1", bus.bandera);
        end
        checks++;
        if (bus.listo !== 1'b0 || bus.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: listo=%b ocupado=%b, required 0 0", bus.listo, bus.ocupado);
        end
    endtask

    task automatic test_ones();
        longint got;
        do_reset();
        for (int i = 0; i < K; i++) write_coef(i, 1);
        for (int s = 1; s <= 8; s++) run_sample(s, 1'b0, 1'b0, 1'b0, 0, 0, got);
        checks++;
        if (got !== 64'sd36) begin
            errors++;
            $display("FAIL ones_sum: got %0d, required 36", got);
        end
    endtask

    task automatic test_impulse();
        int     coefs [K];
        int     want  [K];
        longint got;
        coefs = '{3, -5, 7, 0, 0, 0, 0, 2};
        want  = '{30, -50, 70, 0, 0, 0, 0, 20};
        do_reset();
        for (int i = 0; i < K; i++) write_coef(i, coefs[i]);
        for (int j = 0; j < K; j++) begin
            run_sample((j == 0) ? 10 : 0, 1'b0, 1'b0, 1'b0, 0, 0, got);
            checks++;
            if (got !== longint'(want[j])) begin
                errors++;
                $display("FAIL impulse_%0d: got %0d, required %0d", j, got, want[j]);
            end
        end
    endtask

    task automatic test_inicio_ignored();
        longint got;
        int     extra;
        run_sample(5, 1'b1, 1'b0, 1'b0, 0, 0, got);
        extra = 0;
        for (int i = 0; i < 2 * K; i++) begin
            @(negedge clk);
            if (bus.listo === 1'b1 || bus.ocupado === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignored_inicio: %0d busy/listo cycles after result, required 0", extra);
        end
        run_sample(6, 1'b0, 1'b0, 1'b0, 0, 0, got);
    endtask

    task automatic test_coef_busy();
        longint got;
        run_sample(4, 1'b0, 1'b1, 1'b0, 0, 0, got);
        run_sample(2, 1'b0, 1'b0, 1'b0, 0, 0, got);
        write_coef(0, 99);
        run_sample(1, 1'b0, 1'b0, 1'b0, 0, 0, got);
        checks++;
        if (got !== model_sum() || m_c[0] != 99) begin
            errors++;
            $display("FAIL coef_idle_write: got %0d, required %0d", got, model_sum());
        end
    endtask

    task automatic test_back_to_back();
        longint got;
        int     s, d, v;
        for (int i = 0; i < K; i++) begin
            v = $urandom;
            write_coef(i, v >>> 7);
        end
        for (int it = 0; it < 12; it++) begin
            s = $urandom;
            v = $urandom;
            d = $urandom_range(K - 1, 0);
            run_sample(s >>> 7, 1'b0, 1'b0, (it % 3) == 1, d, v >>> 7, got);
        end
    endtask

    task automatic test_reset_mid_mac();
        int pulses;
        bus.inicio  = 1'b1;
        bus.muestra = 25'd123;
        @(posedge clk);
        #1;
        bus.inicio = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.suma !== '0 || bus.bandera !== 1'b1 || bus.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL mid_mac_reset: suma=%0d bandera=%b ocupado=%b, required 0 1 0",
                     bus.suma, bus.bandera, bus.ocupado);
        end
        pulses = 0;
        for (int i = 0; i < 2 * K; i++) begin
            @(negedge clk);
            if (bus.listo === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mid_mac_listo: %0d pulses, required 0", pulses);
        end
    endtask

    task automatic test_extreme();
        longint got;
        longint want;
        int     m;
        m = -(1 <<< (N - 1));
        do_reset();
        for (int i = 0; i < K; i++) write_coef(i, m);
        for (int j = 0; j < K; j++) run_sample(m, 1'b0, 1'b0, 1'b0, 0, 0, got);
`ifdef FILTRO_SATURACION_EN
        want = SAT_MAX;
`else
        want = 0;
`endif
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL extreme_sum: got %0d, required %0d", got, want);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bus.inicio    = 1'b0;
        bus.muestra   = '0;
        bus.coef_we   = 1'b0;
        bus.coef_dir  = '0;
        bus.coef_dato = '0;
        model_reset();
        test_reset();
        test_ones();
        test_impulse();
        test_inicio_ignored();
        test_coef_busy();
        test_back_to_back();
        test_reset_mid_mac();
        test_extreme();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filtro_mac_secuenciador.md
# filtro_mac_secuenciador

Sequential multiply-accumulate engine that produces the `In`/`Bandera` pair consumed by the filter's hold-register accumulator. Per new input sample it shifts a K-deep signed delay line, multiplies each tap by a programmable coefficient one tap per clock, sums the 2N-bit products, then presents the total on `suma` with `bandera` low for exactly one cycle so the downstream hold register captures it. Sits between the sample source/coefficient loader and the accumulator/output stage of the FIR datapath.

## Interface
- `N`, 25: sample and coefficient width (signed); product and sum width is 2N.
- `K`, 8: number of taps, 2..16.
- `AW`, 3: coefficient address width, `2**AW >= K`.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inicio`  in  1  new-sample strobe; honoured only in IDLE.
- `muestra`  in  N  signed sample, captured with `inicio`.
- `coef_we`  in  1  coefficient write enable.
- `coef_dir`  in  AW  coefficient index.
- `coef_dato`  in  N  signed coefficient value.
- `suma`  out  2N  signed filter result (to accumulator `In`).
- `bandera`  out  1  hold flag (to accumulator `Bandera`); 1 = hold, 0 = load.
- `listo`  out  1  one-cycle pulse, coincident with `bandera`=0.
- `ocupado`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, MAC, PUBLICA.
- IDLE: if `inicio`=1 at an edge: delay line shifts (x[0] <= `muestra`, x[i] <= x[i-1]), internal sum cleared, tap index cleared to 0, go to MAC.
- MAC: each edge sum <= sum + x[idx]*c[idx] (signed 2N-bit product), idx++; on the edge with idx=K-1, `suma` <= final sum, `bandera` <= 0, `listo` <= 1, go to PUBLICA.
- PUBLICA: next edge `bandera` <= 1, `listo` <= 0, go to IDLE.
- `suma` holds its value between results; changes only on the final MAC edge.
- `inicio` in MAC or PUBLICA: ignored, not queued; sample discarded.
- Coefficient writes: accepted only in IDLE (`ocupado`=0); `coef_we` while busy ignored. `coef_dir` >= K ignored. Write coincident with accepted `inicio`: write takes effect, new value is used for that computation.
- Arithmetic: two's complement; default accumulation wraps modulo 2^(2N) (see Configuration).
- Reset (any state, including mid-MAC): state IDLE, delay line and coefficients all 0, `suma`=0, `bandera`=1, `listo`=0, `ocupado`=0; in-flight result lost, no `listo`.

## Timing
- Edge E0 accepts `inicio`; E1..EK perform MAC; `suma` valid and `bandera`=0/`listo`=1 during the cycle after EK; restored at E(K+1).
- Latency `inicio` edge to `listo` high: K cycles; minimum spacing between accepted samples: K+2 cycles.
- `bandera` low exactly one full cycle, so a negedge-sampling consumer captures `suma` once.
- `ocupado` high from the cycle after E0 through the cycle after EK inclusive.

## Configuration
- `FILTRO_SATURACION_EN` defined: each accumulate step clamps to [-2^(2N-1), 2^(2N-1)-1]; once clamped, later steps saturate from the clamped value.
- Undefined: accumulate wraps modulo 2^(2N); no saturation logic built.

## Test plan
- Reset mid-MAC (cycle E3, K=8) -> `suma`=0, `bandera`=1, `ocupado`=0 next cycle, no `listo` pulse.
- Coefs c[i]=1, samples 1..8 fed one per K+2 cycles -> 8th `suma`=36; each `listo` exactly K cycles after its `inicio`.
- Impulse: c = {3,-5,7,0,0,0,0,2}, one sample 10 then zeros -> successive `suma` = 30, -50, 70, 0, 0, 0, 0, 20.
- `inicio` pulsed during MAC and PUBLICA -> ignored; delay line unchanged; one `listo` per accepted sample.
- `coef_we` while `ocupado`=1 (c[0]<=99) -> ignored; next result uses old c[0]; same write in IDLE takes effect.
- N=25, all x=c=-2^24 -> each product 2^48; 8-tap sum with `FILTRO_SATURACION_EN` = 2^49-1, without = wrapped 0.
